// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: load-use, long-unit scoreboard, branch-flush and memory-wait hazard control
module hazard_scoreboard_unit #(
    parameter int NUM_REGS  = 32,
    parameter int REG_AW    = $clog2(NUM_REGS),
    parameter int LU_DEPTH  = 4,
    parameter bit LU_BYPASS = 1'b1,
    parameter int STAT_W    = 16,
    localparam int CNT_W    = $clog2(LU_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_long,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic              id_ex_mem_read,
    input  logic              pc_src,
    input  logic              dmem_stall,
    input  logic              lu_issue,
    input  logic [REG_AW-1:0] lu_issue_rd,
    input  logic              lu_done,
    input  logic [REG_AW-1:0] lu_done_rd,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              flush_id,
    output logic              flush_ex,
    output logic [CNT_W-1:0]  sb_count,
    output logic              sb_full,
    output logic [STAT_W-1:0] stall_cycles
);
    logic [NUM_REGS-1:0] pending, pending_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic rs1_chk, rs2_chk, byp1, byp2;
    logic load_use, sb_raw, sb_waw, struct_hz, hazard;

    assign rs1_chk   = id_rs1_used && id_rs1 != '0;
    assign rs2_chk   = id_rs2_used && id_rs2 != '0;
    assign byp1      = LU_BYPASS && lu_done && lu_done_rd == id_rs1;
    assign byp2      = LU_BYPASS && lu_done && lu_done_rd == id_rs2;
    assign load_use  = id_ex_mem_read && id_ex_rd != '0 &&
                       ((rs1_chk && id_ex_rd == id_rs1) || (rs2_chk && id_ex_rd == id_rs2));
    assign sb_raw    = (rs1_chk && pending[id_rs1] && !byp1) || (rs2_chk && pending[id_rs2] && !byp2);
    assign sb_waw    = id_reg_write && id_rd != '0 && pending[id_rd];
    assign struct_hz = id_long && sb_full && !lu_done;
    assign hazard    = load_use || sb_raw || sb_waw || struct_hz;

    // memory wait outranks a taken branch: the branch re-resolves once the pipe resumes
    assign stall_if = dmem_stall || (!pc_src && hazard);
    assign stall_id = stall_if;
    assign stall_ex = dmem_stall;
    assign flush_id = !dmem_stall && pc_src;
    assign flush_ex = !dmem_stall && (pc_src || hazard);
    assign sb_full  = sb_count == CNT_W'(LU_DEPTH);

    // clear before set so a same-cycle reissue of a completing register stays outstanding
    always_comb begin
        pending_nxt = pending;
        if (lu_done) pending_nxt[lu_done_rd] = 1'b0;
        if (lu_issue && lu_issue_rd != '0) pending_nxt[lu_issue_rd] = 1'b1;
    end

    always_comb
        cnt_nxt = (lu_issue && !lu_done && !sb_full)       ? sb_count + 1'b1 :
                  (lu_done && !lu_issue && sb_count != '0) ? sb_count - 1'b1 : sb_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending      <= '0;
            sb_count     <= '0;
            stall_cycles <= '0;
        end else begin
            pending  <= pending_nxt;
            sb_count <= cnt_nxt;
            if (stall_if && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(lu_issue && !lu_done && sb_full));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(lu_done && !lu_issue && sb_count == '0));
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit: directed scenarios plus randomized traffic against a priority-table model
module tb_hazard_scoreboard_unit;
    localparam int DEPTH = 4;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [4:0] id_rs1, id_rs2, id_rd, id_ex_rd, lu_issue_rd, lu_done_rd;
    logic id_rs1_used, id_rs2_used, id_reg_write, id_long, id_ex_mem_read;
    logic pc_src, dmem_stall, lu_issue, lu_done;
    logic stall_if, stall_id, stall_ex, flush_id, flush_ex, sb_full;
    logic [2:0] sb_count;
    logic [15:0] stall_cycles;
    logic [4:0] outs;
    int tests = 0, fails = 0;
    bit pend [32];
    int m_cnt, m_stalls;

    assign outs = {stall_if, stall_id, stall_ex, flush_id, flush_ex};

    hazard_scoreboard_unit dut (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_long(id_long), .id_ex_rd(id_ex_rd),
        .id_ex_mem_read(id_ex_mem_read), .pc_src(pc_src), .dmem_stall(dmem_stall),
        .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd), .lu_done(lu_done), .lu_done_rd(lu_done_rd),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .flush_id(flush_id),
        .flush_ex(flush_ex), .sb_count(sb_count), .sb_full(sb_full), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic bit src_wait(input bit used, input logic [4:0] r);
        return used && r != 0 && pend[r] && !(lu_done && lu_done_rd == r);
    endfunction

    // expected {stall_if, stall_id, stall_ex, flush_id, flush_ex} from the priority table
    function automatic logic [4:0] exp_out();
        bit lu, hz;
        lu = id_ex_mem_read && id_ex_rd != 0 &&
             ((id_rs1_used && id_rs1 != 0 && id_rs1 == id_ex_rd) ||
              (id_rs2_used && id_rs2 != 0 && id_rs2 == id_ex_rd));
        hz = lu || src_wait(id_rs1_used, id_rs1) || src_wait(id_rs2_used, id_rs2) ||
             (id_reg_write && id_rd != 0 && pend[id_rd]) || (id_long && m_cnt == DEPTH && !lu_done);
        if (dmem_stall) return 5'b11100;
        if (pc_src) return 5'b00011;
        if (hz) return 5'b11001;
        return 5'b00000;
    endfunction

    task automatic model_reset();
        foreach (pend[i]) pend[i] = 1'b0;
        m_cnt = 0;
        m_stalls = 0;
    endtask

    task automatic idle();
        {id_rs1, id_rs2, id_rd, id_ex_rd, lu_issue_rd, lu_done_rd} = '0;
        {id_rs1_used, id_rs2_used, id_reg_write, id_long, id_ex_mem_read} = '0;
        {pc_src, dmem_stall, lu_issue, lu_done} = '0;
    endtask

    // advance one clock from a negedge to the next, updating the model with the held inputs
    task automatic cyc();
        if (exp_out()[4] && m_stalls < 65535) m_stalls++;
        if (lu_done) pend[lu_done_rd] = 1'b0;
        if (lu_issue && lu_issue_rd != 0) pend[lu_issue_rd] = 1'b1;
        if (lu_issue && !lu_done && m_cnt < DEPTH) m_cnt++;
        if (lu_done && !lu_issue && m_cnt > 0) m_cnt--;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        model_reset();
        @(negedge clk);
        tests++; if (outs !== 5'b0) begin fails++; $display("FAIL reset_outs got=%b exp=%b", outs, 5'b0); end
        tests++; if (sb_count !== 3'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", sb_count); end
        tests++; if (sb_full !== 1'b0) begin fails++; $display("FAIL reset_full got=%b exp=0", sb_full); end
        tests++; if (stall_cycles !== 16'd0) begin fails++; $display("FAIL reset_stalls got=%0d exp=0", stall_cycles); end
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < 3; i++) begin
            lu_issue = 1'b1; lu_issue_rd = 5'(3 + i); cyc();
        end
        lu_issue = 1'b0;
        dmem_stall = 1'b1; cyc(); cyc();
        dmem_stall = 1'b0;
        #1;
        tests++; if (sb_count !== 3'd3) begin fails++; $display("FAIL mid_count got=%0d exp=3", sb_count); end
        tests++; if (stall_cycles !== 16'd2) begin fails++; $display("FAIL mid_stalls got=%0d exp=2", stall_cycles); end
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        tests++; if (sb_count !== 3'd0) begin fails++; $display("FAIL async_count got=%0d exp=0", sb_count); end
        tests++; if (stall_cycles !== 16'd0) begin fails++; $display("FAIL async_stalls got=%0d exp=0", stall_cycles); end
        @(negedge clk);
        rst_n = 1'b1;
        id_rs1 = 5'd3; id_rs1_used = 1'b1; id_rs2 = 5'd5; id_rs2_used = 1'b1;
        #1;
        tests++; if (outs !== 5'b0) begin fails++; $display("FAIL async_pending got=%b exp=%b", outs, 5'b0); end
        idle();
    endtask

    task automatic test_load_use();
        id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
        #1;
        tests++; if (outs !== 5'b11001) begin fails++; $display("FAIL load_use got=%b exp=%b", outs, 5'b11001); end
        cyc();
        id_ex_mem_read = 1'b0;
        #1;
        tests++; if (outs !== 5'b0) begin fails++; $display("FAIL load_use_release got=%b exp=%b", outs, 5'b0); end
        id_ex_mem_read = 1'b1; id_ex_rd = 5'd0; id_rs2 = 5'd0;
        #1;
        tests++; if (outs !== 5'b0) begin fails++; $display("FAIL load_use_x0 got=%b exp=%b", outs, 5'b0); end
        id_ex_rd = 5'd5; id_rs2_used = 1'b0; id_rs1 = 5'd5; id_rs1_used = 1'b0;
        #1;
        tests++; if (outs !== 5'b0) begin fails++; $display("FAIL load_use_unused got=%b exp=%b", outs, 5'b0); end
        idle();
    endtask

    task automatic test_raw_long();
        lu_issue = 1'b1; lu_issue_rd = 5'd7; cyc();
        lu_issue = 1'b0; id_rs1 = 5'd7; id_rs1_used = 1'b1; id_rd = 5'd8; id_reg_write = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++; if (outs !== 5'b11001) begin fails++; $display("FAIL raw_wait%0d got=%b exp=%b", i, outs, 5'b11001); end
            cyc();
        end
        lu_done = 1'b1; lu_done_rd = 5'd7;
        #1;
        tests++; if (outs !== 5'b0) begin fails++; $display("FAIL raw_bypass got=%b exp=%b", outs, 5'b0); end
        cyc();
        lu_done = 1'b0;
        #1;
        tests++; if (outs !== 5'b0) begin fails++; $display("FAIL raw_cleared got=%b exp=%b", outs, 5'b0); end
        tests++; if (sb_count !== 3'd0) begin fails++; $display("FAIL raw_count got=%0d exp=0", sb_count); end
        idle();
        id_rd = 5'd7; id_reg_write = 1'b1; lu_issue = 1'b1; lu_issue_rd = 5'd7; cyc();
        lu_issue = 1'b0;
        #1;
        tests++; if (outs !== 5'b11001) begin fails++; $display("FAIL waw got=%b exp=%b", outs, 5'b11001); end
        idle(); lu_done = 1'b1; lu_done_rd = 5'd7; cyc();
        idle();
    endtask

    task automatic test_full();
        for (int i = 1; i <= DEPTH; i++) begin
            lu_issue = 1'b1; lu_issue_rd = 5'(10 + i); cyc();
        end
        lu_issue = 1'b0;
        #1;
        tests++; if (sb_full !== 1'b1) begin fails++; $display("FAIL full_flag got=%b exp=1", sb_full); end
        tests++; if (sb_count !== 3'd4) begin fails++; $display("FAIL full_count got=%0d exp=4", sb_count); end
        id_long = 1'b1;
        #1;
        tests++; if (outs !== 5'b11001) begin fails++; $display("FAIL full_struct got=%b exp=%b", outs, 5'b11001); end
        lu_done = 1'b1; lu_done_rd = 5'd11;
        #1;
        tests++; if (outs !== 5'b0) begin fails++; $display("FAIL full_done_release got=%b exp=%b", outs, 5'b0); end
        cyc();
        id_long = 1'b0;
        for (int i = 2; i <= DEPTH; i++) begin
            lu_done_rd = 5'(10 + i); cyc();
        end
        lu_done = 1'b0;
        #1;
        tests++; if (sb_count !== 3'd0 || sb_full !== 1'b0) begin
            fails++; $display("FAIL full_drain got=%0d/%b exp=0/0", sb_count, sb_full);
        end
        idle();
    endtask

    task automatic test_priority();
        id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1; pc_src = 1'b1;
        #1;
        tests++; if (outs !== 5'b00011) begin fails++; $display("FAIL prio_branch got=%b exp=%b", outs, 5'b00011); end
        dmem_stall = 1'b1;
        #1;
        tests++; if (outs !== 5'b11100) begin fails++; $display("FAIL prio_dmem got=%b exp=%b", outs, 5'b11100); end
        idle();
    endtask

    task automatic test_race();
        lu_issue = 1'b1; lu_issue_rd = 5'd9; cyc();
        lu_done = 1'b1; lu_done_rd = 5'd9; cyc();
        idle();
        #1;
        tests++; if (sb_count !== 3'd1) begin fails++; $display("FAIL race_count got=%0d exp=1", sb_count); end
        id_rs1 = 5'd9; id_rs1_used = 1'b1;
        #1;
        tests++; if (outs !== 5'b11001) begin fails++; $display("FAIL race_pending got=%b exp=%b", outs, 5'b11001); end
        idle(); lu_done = 1'b1; lu_done_rd = 5'd9; cyc();
        idle();
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 400; n++) begin
            id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
            id_rd = 5'($urandom_range(0, 7)); id_ex_rd = 5'($urandom_range(0, 7));
            id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
            id_reg_write = 1'($urandom); id_long = 1'($urandom);
            id_ex_mem_read = 1'($urandom_range(0, 2) == 0);
            pc_src = 1'($urandom_range(0, 7) == 0);
            dmem_stall = 1'($urandom_range(0, 7) == 0);
            lu_done = m_cnt > 0 && $urandom_range(0, 2) == 0;
            lu_done_rd = 5'($urandom_range(0, 7));
            lu_issue = (m_cnt < DEPTH || lu_done) && $urandom_range(0, 2) == 0;
            lu_issue_rd = 5'($urandom_range(0, 7));
            #1;
            tests++; if (outs !== exp_out()) begin fails++; $display("FAIL rnd_outs[%0d] got=%b exp=%b", n, outs, exp_out()); end
            tests++; if (sb_count !== 3'(m_cnt)) begin fails++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", n, sb_count, m_cnt); end
            tests++; if (sb_full !== (m_cnt == DEPTH)) begin fails++; $display("FAIL rnd_full[%0d] got=%b exp=%b", n, sb_full, m_cnt == DEPTH); end
            tests++; if (stall_cycles !== 16'(m_stalls)) begin fails++; $display("FAIL rnd_stalls[%0d] got=%0d exp=%0d", n, stall_cycles, m_stalls); end
            cyc();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        test_load_use();
        test_raw_long();
        test_full();
        test_priority();
        test_race();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
